// File: rtl/ps2_attack_decoder_pkg.sv
// Shared definitions for the PS/2 attack decoder and the gameplay backend:
// attack codes, PS/2 prefix bytes, frame FSM encoding and a parity helper.
package ps2_attack_decoder_pkg;

  // Attack codes driven on keyboard_input, also decoded by the backend
  typedef enum logic [3:0] {
    ATK_STANDBY = 4'b0000,
    ATK_LIGHT   = 4'b0001,
    ATK_HEAVY   = 4'b0010
  } attack_t;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

  // Frame FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity holds when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_attack_decoder_if.sv
// Bundle of the PS/2 pins and the decoded outputs of ps2_attack_decoder.
// master: the decoder (reads pins, drives results); slave: keyboard side/consumer.
interface ps2_attack_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyboard_input;
  logic       frame_error;
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keyboard_input,
    output frame_error,
    output rx_byte,
    output rx_valid
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keyboard_input,
    input  frame_error,
    input  rx_byte,
    input  rx_valid
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output level flips
// only after FILTER_LEN consecutive synchronized samples at the new value.
// Idles (and resets) high, matching an undriven PS/2 line.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out
);

  localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run_cnt;

  // Synchronize the raw pin and debounce the synchronized level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '1;
      run_cnt  <= '0;
      line_out <= 1'b1;
    end else begin
      sync <= {sync[0], line_in};
      if (sync[1] == line_out) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        line_out <= sync[1];
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_attack_decoder.sv
// PS/2 keyboard front-end: receives frames, decodes scancodes and emits a
// single-cycle LIGHT/HEAVY attack code per fresh key press.
// Optional feature macro: ATTACK_COOLDOWN_EN (attack lockout after each emit).
module ps2_attack_decoder
  import ps2_attack_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN      = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned COOLDOWN_CYCLES = 5000000,
  parameter logic [7:0]  LIGHT_CODE      = 8'h1C,
  parameter logic [7:0]  HEAVY_CODE      = 8'h1B
) (
  input logic                  clk,
  input logic                  reset,
  ps2_attack_decoder_if.master bus
);

  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  if (FILTER_LEN < 1 || TIMEOUT_CYCLES < 1 || COOLDOWN_CYCLES < 1) begin : g_bad_param
    $error("ps2_attack_decoder: FILTER_LEN, TIMEOUT_CYCLES and COOLDOWN_CYCLES must be >= 1");
  end

  logic ps2_clk_f;
  logic ps2_data_f;
  logic ps2_clk_f_d;
  logic strobe;

  logic [1:0]     state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           parity_ok;
  logic [TCW-1:0] tmo_cnt;
  logic [7:0]     rx_byte_q;
  logic           rx_valid_q;
  logic           frame_error_q;

  logic    break_pend;
  logic    ext_pend;
  logic    held_light;
  logic    held_heavy;
  attack_t kb_q;
  logic    is_make;
  logic    light_hit;
  logic    heavy_hit;
  logic    emit_ok;
  logic    light_fire;
  logic    heavy_fire;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (bus.ps2_clk),
    .line_out (ps2_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (bus.ps2_data),
    .line_out (ps2_data_f)
  );

  assign strobe = ps2_clk_f_d & ~ps2_clk_f;

  // Frame reception: start, 8 data bits LSB-first, odd parity, stop, with inter-strobe timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_f_d   <= 1'b1;
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_ok     <= 1'b0;
      tmo_cnt       <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      ps2_clk_f_d   <= ps2_clk_f;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      if (state != ST_IDLE && tmo_cnt == TCW'(TIMEOUT_CYCLES)) begin
        state         <= ST_IDLE;
        frame_error_q <= 1'b1;
        tmo_cnt       <= '0;
        bit_cnt       <= '0;
        shift         <= '0;
      end else begin
        if (strobe || state == ST_IDLE) begin
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        if (strobe) begin
          case (state)
            ST_IDLE: begin
              if (!ps2_data_f) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end else begin
                frame_error_q <= 1'b1;
              end
            end
            ST_DATA: begin
              shift   <= {ps2_data_f, shift[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state <= ST_PARITY;
              end
            end
            ST_PARITY: begin
              parity_ok <= odd_parity_ok(shift, ps2_data_f);
              state     <= ST_STOP;
            end
            ST_STOP: begin
              if (ps2_data_f && parity_ok) begin
                rx_byte_q  <= shift;
                rx_valid_q <= 1'b1;
              end else begin
                frame_error_q <= 1'b1;
              end
              state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

`ifdef ATTACK_COOLDOWN_EN
  localparam int unsigned CDW = $clog2(COOLDOWN_CYCLES + 1);

  logic [CDW-1:0] cd_cnt;

  // Lockout counter reloads on every emitted attack and counts down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cd_cnt <= '0;
    end else if (light_fire || heavy_fire) begin
      cd_cnt <= CDW'(COOLDOWN_CYCLES);
    end else if (cd_cnt != '0) begin
      cd_cnt <= cd_cnt - 1'b1;
    end
  end

  assign emit_ok = (cd_cnt == '0);
`else
  assign emit_ok = 1'b1;
`endif

  // Classify the received byte as a fresh make of a mapped key
  always_comb begin
    is_make    = rx_valid_q && (rx_byte_q != PS2_BREAK_PREFIX) && (rx_byte_q != PS2_EXT_PREFIX)
                 && !break_pend && !ext_pend;
    light_hit  = is_make && (rx_byte_q == LIGHT_CODE) && !held_light;
    heavy_hit  = is_make && (rx_byte_q == HEAVY_CODE) && (rx_byte_q != LIGHT_CODE) && !held_heavy;
    light_fire = light_hit && emit_ok;
    heavy_fire = heavy_hit && emit_ok;
  end

  // Scancode layer: prefix tracking, held-key flags and the registered attack pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      held_light <= 1'b0;
      held_heavy <= 1'b0;
      kb_q       <= ATK_STANDBY;
    end else begin
      kb_q <= ATK_STANDBY;
      if (rx_valid_q) begin
        if (rx_byte_q == PS2_BREAK_PREFIX) begin
          break_pend <= 1'b1;
        end else if (rx_byte_q == PS2_EXT_PREFIX) begin
          ext_pend <= 1'b1;
        end else if (break_pend) begin
          if (rx_byte_q == LIGHT_CODE) held_light <= 1'b0;
          if (rx_byte_q == HEAVY_CODE) held_heavy <= 1'b0;
          break_pend <= 1'b0;
          ext_pend   <= 1'b0;
        end else if (ext_pend) begin
          break_pend <= 1'b0;
          ext_pend   <= 1'b0;
        end else begin
          // Held flags latch even when the cooldown swallows the emit
          if (light_hit) held_light <= 1'b1;
          if (heavy_hit) held_heavy <= 1'b1;
          if (light_fire) begin
            kb_q <= ATK_LIGHT;
          end else if (heavy_fire) begin
            kb_q <= ATK_HEAVY;
          end
        end
      end
    end
  end

  assign bus.keyboard_input = kb_q;
  assign bus.frame_error    = frame_error_q;
  assign bus.rx_byte        = rx_byte_q;
  assign bus.rx_valid       = rx_valid_q;

endmodule

// File: doc/ps2_attack_decoder.md
# ps2_attack_decoder

Keyboard front-end for the gameplay backend. Receives PS/2 frames from the keyboard, decodes scancodes, and produces the 4-bit attack-type code consumed as `keyboard_input` by the backend health/punch logic. Each fresh key press yields exactly one single-cycle LIGHT or HEAVY code. The output is STANDBY at all other times.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive equal synchronized samples needed to accept a PS/2 line level change.
- `TIMEOUT_CYCLES`, 100000: max clk cycles between PS/2 clock falling edges inside a frame (10 ms at 10 MHz).
- `COOLDOWN_CYCLES`, 5000000: attack lockout length; used only with `ATTACK_COOLDOWN_EN`.
- `LIGHT_CODE`, 8'h1C: make code mapped to LIGHT (key A).
- `HEAVY_CODE`, 8'h1B: make code mapped to HEAVY (key S).

Ports:
- `clk`, in, 1: system clock, 10 MHz.
- `reset`, in, 1: synchronous, active-high.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data, asynchronous.
- `keyboard_input`, out, 4: attack type. 4'b0000 STANDBY, 4'b0001 LIGHT, 4'b0010 HEAVY.
- `frame_error`, out, 1: one-cycle pulse on parity, start, stop or timeout failure.
- `rx_byte`, out, 8: last good received byte (debug).
- `rx_valid`, out, 1: one-cycle pulse when `rx_byte` updates.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass a 2-FF synchronizer.
  - Each filter flips its level only after `FILTER_LEN` consecutive samples at the new value. Filters reset to 1.
  - A falling edge on the filtered clock is a "bit strobe".
- Frame FSM:
  - States IDLE, DATA, PARITY, STOP.
  - IDLE: a bit strobe with data=0 moves to DATA. A strobe with data=1 raises `frame_error` and stays in IDLE.
  - DATA: shifts 8 bits LSB-first, using a 3-bit counter. After bit 7 it moves to PARITY.
  - PARITY: records the bit and checks odd parity over data plus parity.
  - STOP: needs data=1. On success, latch `rx_byte` and pulse `rx_valid`. Otherwise pulse `frame_error`. Both paths return to IDLE.
  - Timeout counter clears on every strobe and runs in any state except IDLE. On reaching `TIMEOUT_CYCLES`, the FSM returns to IDLE, pulses `frame_error`, and discards partial data.
- Scancode layer, acting on each `rx_valid` byte:
  - 8'hF0 sets `break_pend`. 8'hE0 sets `ext_pend`.
  - Any other byte with `break_pend` set: clear the held flag for that code (LIGHT/HEAVY only), then clear both pend flags.
  - Any other byte with `ext_pend` set: ignored, then clear both pend flags.
  - Otherwise it is a make code. If it matches `LIGHT_CODE` or `HEAVY_CODE` and that key's held flag is clear, emit the attack and set the held flag. If the held flag is already set, it is a typematic repeat and is suppressed.
  - Unmapped codes have no effect.
- `keyboard_input` is registered and returns to STANDBY the cycle after an emit.
- Reset mid-frame aborts the frame and clears pend and held flags. No output pulse is produced.

## Timing
- Reset values:
  - `keyboard_input` = 4'b0000, `frame_error` = 0, `rx_valid` = 0, `rx_byte` = 8'h00.
  - FSM in IDLE, all counters and flags 0.
- Strobe latency: a PS/2 clock fall is detected 2 + `FILTER_LEN` clk cycles after the pin changes.
- Decode latency:
  - `rx_valid` asserts 1 cycle after the stop-bit strobe.
  - `keyboard_input` asserts 1 cycle after `rx_valid` and holds for exactly 1 cycle.
- `frame_error` and `rx_valid` never assert in the same cycle.
- At most one of LIGHT or HEAVY is emitted per byte. A single frame carries one byte, so simultaneous emits cannot occur.
- Held flags are independent: holding A does not block S.

## Configuration
- `ATTACK_COOLDOWN_EN` defined:
  - After any emitted attack, a down-counter loads `COOLDOWN_CYCLES`.
  - While it is nonzero, new LIGHT/HEAVY emits are suppressed. Held flags still update, so a press during cooldown is consumed and not replayed later.
  - The counter clears on reset.
- `ATTACK_COOLDOWN_EN` undefined: no counter, and every qualifying fresh press emits.

## Structure
- Shared package holds:
  - attack codes STANDBY/LIGHT/HEAVY (4-bit), also used by the backend;
  - PS/2 prefix constants 8'hF0 and 8'hE0;
  - frame FSM state encoding.
- Sub-module `ps2_line_filter`: synchronizer plus `FILTER_LEN` glitch filter, instantiated twice (clock and data).
- Frame FSM and scancode layer stay in the top module.

## Test plan
- Good frame 8'h1C (parity 0) → `rx_valid` pulse, `rx_byte`=8'h1C, then `keyboard_input`=4'b0001 for exactly 1 cycle, then 4'b0000.
- Sequence 1B, 1B, 1B, F0 1B, 1B → exactly two 4'b0010 pulses (first make and post-break make).
- 8'h1C frame with parity bit flipped → `frame_error` pulse, no `rx_valid`, `keyboard_input` stays 0000. A following good 1C frame emits 0001.
- Start bit plus 5 data bits, then idle for `TIMEOUT_CYCLES`+10 → one `frame_error` pulse, FSM in IDLE. The next good frame decodes correctly.
- E0 1C → `rx_valid` twice, no attack output. Then 1C → 0001.
- With `ATTACK_COOLDOWN_EN`, `COOLDOWN_CYCLES`=1000:
  - 1C, F0 1C, 1C within 1000 cycles → one pulse only.
  - The same sequence spaced by more than 1000 cycles → two pulses.
